multicycle_ctrl: RTL
====================

Name: multicycle_ctrl

Overview:
Main control FSM that runs the existing RV32 subset datapath (add/sub/sll/or/and, addi/slli, lw, lwi, sw, beq/blt) as a multi-cycle machine instead of a single-cycle one. Each instruction passes through the states FETCH, DECODE, EXEC, optional MEM, and optional WB.
- Instruction and data memories are reached through req/ready handshakes.
- The block drives every datapath enable and mux select.
- It counts retired instructions.

Parameters:
- CNT_W, 32, width of the retired-instruction counter instret.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- inst_opcode  in  7  inst[6:0] of the instruction currently on the imem read bus.
- takebranch  in  1  branch-condition result from the ALU; valid in EXEC.
- imem_ready  in  1  instruction-fetch handshake completion.
- dmem_ready  in  1  data-memory handshake completion.
- imem_req  out  1  fetch request.
- dmem_req  out  1  data-memory request.
- ir_write  out  1  load the instruction register.
- ab_write  out  1  latch register-file outputs into the A/B registers.
- aluout_write  out  1  latch the ALU result.
- mdr_write  out  1  latch memory read data.
- pc_write  out  1  update PC.
- pc_src  out  1  0 selects PC+4; 1 selects PC+imm.
- alusrc  out  1  0 selects B; 1 selects immediate.
- aluop  out  2  0 add, 1 sub/branch, 2 funct-decoded.
- memread  out  1
- memwrite  out  1
- memtoreg  out  1
- regwrite  out  1
- instret  out  CNT_W  retired-instruction count.
- trap  out  1  illegal-opcode flag; only exists when the optional feature is enabled.

Behaviour:
- Reset (rst=0, asynchronous): state=S_IDLE, latched opcode=0, instret=0, trap=0.
  - All outputs are 0 while in reset and while in S_IDLE.
  - S_IDLE moves to S_FETCH unconditionally on the first clk edge after rst rises.
- Outputs are combinational decodes of (state, latched opcode). Transitions happen on the rising edge of clk.
- S_FETCH: imem_req=1.
  - imem_ready=1: ir_write=1, the opcode register captures inst_opcode, go to S_DECODE.
  - Otherwise stay in S_FETCH with imem_req held at 1.
- S_DECODE: ab_write=1. The opcode is classified as R (0110011), I (0010011), LW (0000011), LWI (0000111), SW (0100011), BR (1100011), or ILLEGAL.
  - Legal opcodes go to S_EXEC.
  - ILLEGAL: see Optional Feature.
- S_EXEC: aluout_write=1.
  - R: alusrc=0, aluop=2, go to S_WB.
  - I: alusrc=1, aluop=2, go to S_WB.
  - LW and SW: alusrc=1, aluop=0, go to S_MEM.
  - LWI: alusrc=0, aluop=0 (address is rs1+rs2), go to S_MEM.
  - BR: alusrc=0, aluop=1, pc_write=1, pc_src=takebranch, instret+1, go to S_FETCH.
- S_MEM: dmem_req=1. memread=1 for LW/LWI; memwrite=1 for SW. Both signals are held until dmem_ready.
  - LW/LWI with dmem_ready=1: mdr_write=1, go to S_WB.
  - SW with dmem_ready=1: pc_write=1, pc_src=0, instret+1, go to S_FETCH.
  - memwrite must be high for exactly the cycle in which dmem_ready=1 is sampled, plus any preceding wait cycles. There is never a write without req.
- S_WB: regwrite=1, memtoreg=1 for LW/LWI, pc_write=1, pc_src=0, instret+1, go to S_FETCH.
- Latency with zero-wait memories:
  - R/I: 4 cycles.
  - BR: 3 cycles.
  - SW: 4 cycles.
  - LW/LWI: 5 cycles.
  - Each ready wait cycle adds 1.
- Boundary conditions:
  - imem_ready or dmem_ready asserted outside S_FETCH or S_MEM is ignored.
  - instret wraps modulo 2^CNT_W without saturating.
  - rst low mid-instruction aborts immediately; no regwrite, memwrite or pc_write is issued for the aborted instruction.
  - pc_write asserts exactly once per retired instruction. instret increments in the same cycle as that pc_write.

Optional Feature:
- Macro MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined: an ILLEGAL opcode in S_DECODE goes to S_TRAP.
  - S_TRAP holds trap=1 with all other outputs 0 until reset.
  - PC is not written and instret is not incremented.
- Undefined: an ILLEGAL opcode is executed as a NOP. S_DECODE asserts pc_write=1, pc_src=0, instret+1, and goes to S_FETCH. The trap port and S_TRAP are absent.

Decomposition:
- Shared package multicycle_pkg holds:
  - The state enum: S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP.
  - Opcode constants OP_R, OP_I, OP_LW, OP_LWI, OP_SW, OP_BR.
  - aluop constants ALUOP_ADD=0, ALUOP_SUB=1, ALUOP_FUNCT=2.
  - The instruction-class enum.
- One sub-module, opcode_classify: combinational, maps 7-bit opcode to a class.
- The FSM and instret counter stay in multicycle_ctrl.

Test Plan:
- Reset then add with zero-wait memories → cycles show IDLE, FETCH, DECODE, EXEC, WB; regwrite=1 only in WB; instret=1 after WB.
- lw with dmem_ready delayed 3 cycles → memread and dmem_req high for 4 cycles, mdr_write once, memtoreg=1 in WB; instret increments once.
- beq with takebranch=1, then blt with takebranch=0 → pc_write=1 in EXEC with pc_src=1, then pc_src=0; regwrite never asserted.
- sw then lwi back to back → memwrite only in sw MEM; lwi EXEC alusrc=0, aluop=0; instret=2.
- rst pulled low in S_MEM of sw with dmem_ready=0 → state=S_IDLE immediately, no memwrite or pc_write, instret=0.
- Opcode 0x7F: with the macro defined, trap=1 sticky and instret unchanged; without it, NOP behaviour with pc_write in DECODE and instret+1.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and constants for the multi-cycle RV32-subset control FSM.
// Consumed by multicycle_ctrl and opcode_classify.
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } state_e;

    typedef enum logic [2:0] {
        CLS_R,
        CLS_I,
        CLS_LW,
        CLS_LWI,
        CLS_SW,
        CLS_BR,
        CLS_ILLEGAL
    } iclass_e;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_LWI = 7'b0000111;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [1:0] ALUOP_ADD   = 2'd0;
    localparam logic [1:0] ALUOP_SUB   = 2'd1;
    localparam logic [1:0] ALUOP_FUNCT = 2'd2;

    function automatic logic is_load(input iclass_e cls);
        return (cls == CLS_LW) || (cls == CLS_LWI);
    endfunction

endpackage

// File: rtl/multicycle_ctrl_opcode_classify.sv
// Combinational opcode classifier: maps inst[6:0] to an instruction class.
module opcode_classify
    import multicycle_pkg::*;
(
    input  logic [6:0] opcode_i,
    output iclass_e    class_o
);

    always_comb begin
        class_o = CLS_ILLEGAL;
        case (opcode_i)
            OP_R:    class_o = CLS_R;
            OP_I:    class_o = CLS_I;
            OP_LW:   class_o = CLS_LW;
            OP_LWI:  class_o = CLS_LWI;
            OP_SW:   class_o = CLS_SW;
            OP_BR:   class_o = CLS_BR;
            default: class_o = CLS_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32-subset datapath with retired-instruction counter.
// Optional MULTICYCLE_CTRL_ILLEGAL_TRAP_EN: illegal opcodes trap (sticky) instead of retiring as NOP.
module multicycle_ctrl
    import multicycle_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       inst_opcode,
    input  logic             takebranch,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             ir_write,
    output logic             ab_write,
    output logic             aluout_write,
    output logic             mdr_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alusrc,
    output logic [1:0]       aluop,
    output logic             memread,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             regwrite,
    output logic [CNT_W-1:0] instret
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
    ,
    output logic             trap
`endif
);

    state_e           state_q;
    logic [6:0]       opcode_q;
    logic [CNT_W-1:0] instret_q;
    iclass_e          cls;

    opcode_classify u_classify (
        .opcode_i (opcode_q),
        .class_o  (cls)
    );

    assign instret = instret_q;

    // instret tracks pc_write so the two can never disagree about a retirement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            opcode_q  <= '0;
            instret_q <= '0;
        end else begin
            if (pc_write) begin
                instret_q <= instret_q + CNT_W'(1);
            end
            case (state_q)
                S_IDLE: state_q <= S_FETCH;
                S_FETCH: begin
                    if (imem_ready) begin
                        opcode_q <= inst_opcode;
                        state_q  <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    if (cls == CLS_ILLEGAL) begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                        state_q <= S_TRAP;
`else
                        state_q <= S_FETCH;
`endif
                    end else begin
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    case (cls)
                        CLS_R, CLS_I:           state_q <= S_WB;
                        CLS_LW, CLS_LWI, CLS_SW: state_q <= S_MEM;
                        default:                state_q <= S_FETCH;
                    endcase
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        state_q <= is_load(cls) ? S_WB : S_FETCH;
                    end
                end
                S_WB:   state_q <= S_FETCH;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                S_TRAP: state_q <= S_TRAP;
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        ir_write     = 1'b0;
        ab_write     = 1'b0;
        aluout_write = 1'b0;
        mdr_write    = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        alusrc       = 1'b0;
        aluop        = ALUOP_ADD;
        memread      = 1'b0;
        memwrite     = 1'b0;
        memtoreg     = 1'b0;
        regwrite     = 1'b0;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        trap         = 1'b0;
`endif
        case (state_q)
            S_FETCH: begin
                imem_req = 1'b1;
                ir_write = imem_ready;
            end
            S_DECODE: begin
                ab_write = 1'b1;
`ifndef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
                pc_write = (cls == CLS_ILLEGAL);
`endif
            end
            S_EXEC: begin
                aluout_write = 1'b1;
                case (cls)
                    CLS_R: aluop = ALUOP_FUNCT;
                    CLS_I: begin
                        alusrc = 1'b1;
                        aluop  = ALUOP_FUNCT;
                    end
                    CLS_LW, CLS_SW: alusrc = 1'b1;
                    CLS_BR: begin
                        aluop    = ALUOP_SUB;
                        pc_write = 1'b1;
                        pc_src   = takebranch;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                dmem_req = 1'b1;
                memread  = is_load(cls);
                memwrite = (cls == CLS_SW);
                if (dmem_ready) begin
                    mdr_write = is_load(cls);
                    pc_write  = (cls == CLS_SW);
                end
            end
            S_WB: begin
                regwrite = 1'b1;
                memtoreg = is_load(cls);
                pc_write = 1'b1;
            end
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
            S_TRAP: trap = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule
